// File: rtl/branch_redirect_unit.sv
// Branch resolution ahead of the PC: accepts one branch, waits for flags,
// redirects the PC for one cycle, then holds flush for FLUSH_CYCLES more.
module branch_redirect_unit #(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] pc,
  input  logic       br_valid,
  output logic       br_ready,
  input  logic [7:0] br_pc,
  input  logic [7:0] br_offset,
  input  logic [1:0] br_cond,
  input  logic       flags_valid,
  input  logic       flag_z,
  input  logic       flag_n,
  output logic [7:0] pc_control,
  output logic [7:0] jump_offset,
  output logic       flush,
  output logic [7:0] taken_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_REDIR,
    S_FLUSH
  } state_t;

  localparam logic [3:0] FC = 4'(FLUSH_CYCLES);

  state_t     state_q, state_d;
  logic [7:0] tgt_q, tgt_d;
  logic [1:0] cond_q, cond_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] taken_q, taken_d;
  logic       cond_true;

  always_comb begin
    cond_true = 1'b0;
    unique case (cond_q)
      2'b00: cond_true = 1'b1;
      2'b01: cond_true = flag_z;
      2'b10: cond_true = ~flag_z;
      2'b11: cond_true = flag_n;
    endcase
  end

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    cond_d  = cond_q;
    cnt_d   = cnt_q;
    taken_d = taken_q;
    unique case (state_q)
      S_IDLE: begin
        if (br_valid) begin
          tgt_d   = br_pc + br_offset;
          cond_d  = br_cond;
          state_d = (br_cond == 2'b00) ? S_REDIR : S_WAIT;
        end
      end
      S_WAIT: begin
        if (flags_valid) begin
          state_d = cond_true ? S_REDIR : S_IDLE;
        end
      end
      S_REDIR: begin
        if (taken_q != 8'hFF) begin
          taken_d = taken_q + 8'd1;
        end
        cnt_d   = FC;
        state_d = (FC == 4'd0) ? S_IDLE : S_FLUSH;
      end
      S_FLUSH: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      tgt_q   <= 8'd0;
      cond_q  <= 2'b00;
      cnt_q   <= 4'd0;
      taken_q <= 8'd0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      cond_q  <= cond_d;
      cnt_q   <= cnt_d;
      taken_q <= taken_d;
    end
  end

  // Offset is relative to the live PC so that pc + 1 + offset hits tgt + 1.
  assign br_ready    = (state_q == S_IDLE);
  assign pc_control  = (state_q == S_REDIR) ? 8'hFF : 8'h00;
  assign jump_offset = (state_q == S_REDIR) ? (tgt_q - pc) : 8'h00;
  assign flush       = (state_q == S_REDIR) || (state_q == S_FLUSH);
  assign taken_count = taken_q;

endmodule

// File: tb/tb_branch_redirect_unit.sv
// Directed bench for branch_redirect_unit with a PC model and a
// landing-address scoreboard checked on every redirect cycle.
module tb_branch_redirect_unit;

  localparam int FC = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] pc;
  logic       br_valid;
  logic       br_ready;
  logic [7:0] br_pc;
  logic [7:0] br_offset;
  logic [1:0] br_cond;
  logic       flags_valid;
  logic       flag_z;
  logic       flag_n;
  logic [7:0] pc_control;
  logic [7:0] jump_offset;
  logic       flush;
  logic [7:0] taken_count;

  logic       pc_ld;
  logic [7:0] pc_ld_val;
  logic [7:0] exp_q[$];
  logic [7:0] p0;
  int         tests = 0;
  int         fails = 0;

  branch_redirect_unit #(.FLUSH_CYCLES(FC)) dut (
    .clk        (clk),
    .reset      (reset),
    .pc         (pc),
    .br_valid   (br_valid),
    .br_ready   (br_ready),
    .br_pc      (br_pc),
    .br_offset  (br_offset),
    .br_cond    (br_cond),
    .flags_valid(flags_valid),
    .flag_z     (flag_z),
    .flag_n     (flag_n),
    .pc_control (pc_control),
    .jump_offset(jump_offset),
    .flush      (flush),
    .taken_count(taken_count)
  );

  always #5 clk = ~clk;

  // Program counter driven by the unit's mask and offset.
  always @(posedge clk) begin
    if (pc_ld) pc <= pc_ld_val;
    else pc <= pc + 8'd1 + (jump_offset & pc_control);
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (pc_control == 8'hFF) begin
      chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        chk("sb_land", 32'(8'(pc + 8'd1 + jump_offset)),
            32'(exp_q.pop_front()));
      end
    end else begin
      chk("pcc_quiet", 32'(pc_control), 32'h0);
      chk("jo_quiet", 32'(jump_offset), 32'h0);
    end
  end

  task automatic run_br(input logic [7:0] bpc, input logic [7:0] off,
                        input logic [1:0] cond, input logic z,
                        input logic n, input logic tk);
    logic [7:0] e;
    e = bpc + 8'd1 + off;
    br_valid  = 1'b1;
    br_pc     = bpc;
    br_offset = off;
    br_cond   = cond;
    if (tk) exp_q.push_back(e);
    tick();
    br_valid = 1'b0;
    if (cond != 2'b00) begin
      chk("wait_rdy", 32'(br_ready), 32'd0);
      flags_valid = 1'b1;
      flag_z      = z;
      flag_n      = n;
      tick();
      flags_valid = 1'b0;
    end
    if (tk) begin
      chk("redir_pcc", 32'(pc_control), 32'hFF);
      chk("redir_flush", 32'(flush), 32'd1);
      tick();
      chk("land_pc", 32'(pc), 32'(e));
      repeat (FC) begin
        chk("flush_hold", 32'(flush), 32'd1);
        tick();
      end
    end else begin
      chk("nt_pcc", 32'(pc_control), 32'h0);
    end
    chk("end_rdy", 32'(br_ready), 32'd1);
    chk("end_flush", 32'(flush), 32'd0);
  endtask

  initial begin
    reset       = 1'b1;
    br_valid    = 1'b1;
    br_pc       = 8'd0;
    br_offset   = 8'd0;
    br_cond     = 2'b00;
    flags_valid = 1'b0;
    flag_z      = 1'b0;
    flag_n      = 1'b0;
    pc_ld       = 1'b1;
    pc_ld_val   = 8'd0;

    // Reset dominates a pending request
    tick();
    tick();
    chk("rst_pcc", 32'(pc_control), 32'h0);
    chk("rst_jo", 32'(jump_offset), 32'h0);
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_rdy", 32'(br_ready), 32'd1);
    chk("rst_taken", 32'(taken_count), 32'd0);
    reset    = 1'b0;
    br_valid = 1'b0;
    tick();
    chk("rst_noredir", 32'(flush), 32'd0);

    // Unconditional: br_pc=8 off=20 accepted with pc=10
    pc_ld_val = 8'd10;
    tick();
    pc_ld = 1'b0;
    chk("u_pc10", 32'(pc), 32'd10);
    br_valid  = 1'b1;
    br_pc     = 8'd8;
    br_offset = 8'd20;
    br_cond   = 2'b00;
    exp_q.push_back(8'd29);
    tick();
    br_valid = 1'b0;
    chk("u_pc11", 32'(pc), 32'd11);
    chk("u_jo", 32'(jump_offset), 32'd17);
    chk("u_pcc", 32'(pc_control), 32'hFF);
    chk("u_fl0", 32'(flush), 32'd1);
    tick();
    chk("u_land", 32'(pc), 32'd29);
    chk("u_fl1", 32'(flush), 32'd1);
    chk("u_taken", 32'(taken_count), 32'd1);
    tick();
    chk("u_fl2", 32'(flush), 32'd1);
    tick();
    chk("u_fl3", 32'(flush), 32'd0);
    chk("u_rdy", 32'(br_ready), 32'd1);

    // Not taken after 3 wait cycles
    br_valid  = 1'b1;
    br_pc     = 8'd50;
    br_offset = 8'd5;
    br_cond   = 2'b01;
    tick();
    br_valid = 1'b0;
    p0 = pc;
    repeat (3) begin
      chk("nt_wait_rdy", 32'(br_ready), 32'd0);
      chk("nt_wait_fl", 32'(flush), 32'd0);
      tick();
    end
    flags_valid = 1'b1;
    flag_z      = 1'b0;
    tick();
    flags_valid = 1'b0;
    chk("nt_rdy", 32'(br_ready), 32'd1);
    chk("nt_flush", 32'(flush), 32'd0);
    chk("nt_pc", 32'(pc), 32'(8'(p0 + 8'd4)));
    chk("nt_taken", 32'(taken_count), 32'd1);

    // Wrap forward and backward branch
    run_br(8'd250, 8'd10, 2'b11, 1'b0, 1'b1, 1'b1);
    chk("wrap_taken", 32'(taken_count), 32'd2);
    run_br(8'd40, 8'hF6, 2'b10, 1'b0, 1'b0, 1'b1);
    chk("back_taken", 32'(taken_count), 32'd3);
    run_br(8'd60, 8'd3, 2'b01, 1'b0, 1'b1, 1'b0);
    run_br(8'd70, 8'd4, 2'b11, 1'b1, 1'b0, 1'b0);
    run_br(8'd80, 8'd2, 2'b01, 1'b1, 1'b0, 1'b1);
    chk("z_taken", 32'(taken_count), 32'd4);

    // Reset during FLUSH
    br_valid  = 1'b1;
    br_pc     = 8'd100;
    br_offset = 8'd7;
    br_cond   = 2'b00;
    exp_q.push_back(8'd108);
    tick();
    br_valid = 1'b0;
    tick();
    chk("mr_in_flush", 32'(flush), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mr_flush", 32'(flush), 32'd0);
    chk("mr_rdy", 32'(br_ready), 32'd1);
    chk("mr_taken", 32'(taken_count), 32'd0);

    // Reset while waiting for flags aborts the branch
    br_valid = 1'b1;
    br_cond  = 2'b01;
    tick();
    br_valid = 1'b0;
    chk("mw_wait", 32'(br_ready), 32'd0);
    reset       = 1'b1;
    flags_valid = 1'b1;
    flag_z      = 1'b1;
    tick();
    reset       = 1'b0;
    flags_valid = 1'b0;
    repeat (3) begin
      chk("mw_flush", 32'(flush), 32'd0);
      chk("mw_rdy", 32'(br_ready), 32'd1);
      tick();
    end

    // Saturation with br_valid held high
    br_valid  = 1'b1;
    br_pc     = 8'd0;
    br_offset = 8'd1;
    br_cond   = 2'b00;
    for (int i = 0; i < 260; i++) begin
      chk("sat_rdy", 32'(br_ready), 32'd1);
      exp_q.push_back(8'd2);
      tick();
      for (int k = 0; k < 1 + FC; k++) begin
        chk("sat_busy", 32'(br_ready), 32'd0);
        tick();
      end
    end
    br_valid = 1'b0;
    chk("sat_cnt", 32'(taken_count), 32'd255);
    tick();
    tick();
    chk("sat_hold", 32'(taken_count), 32'd255);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
